// File: rtl/mem_access_ctrl_if.sv
// Port bundle between the fetch/load-store requesters, the arbiter and mem32.
// Master drives requests and the memory read data; slave is the controller.
interface mem_access_ctrl_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_signed;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;

  logic [15:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;

  logic        busy;

  modport master (
    output i_req, i_addr, d_req, d_we, d_size, d_signed, d_addr, d_wdata, mem_q,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_address, mem_data, mem_wren, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_size, d_signed, d_addr, d_wdata, mem_q,
    output i_ack, i_rdata, d_ack, d_rdata, mem_address, mem_data, mem_wren, busy
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Shares the single mem32 port between instruction fetch and load/store;
// sub-word stores are read-modify-write since mem32 always writes 4 bytes.
//   state | meaning
//   IDLE  | arbitrate, latch the granted request
//   WR    | word store write cycle, d_ack
//   RD_A  | read address presented to memory
//   RD_D  | mem_q valid, formatted data + ack
//   RMW_A | sub-word store: read address presented
//   RMW_M | merge new bytes into the read word
//   RMW_W | write merged word, d_ack
module mem_access_ctrl (
  input  logic clock,
  input  logic resetn,
  mem_access_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WR, RD_A, RD_D, RMW_A, RMW_M, RMW_W} state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_t      state;
  logic        last_grant;
  logic        port_r;
  logic        signed_r;
  logic [1:0]  size_r;
  logic [15:0] addr_r;
  logic [15:0] wdata_lo;
  logic [31:0] mem_data_r;
  logic        wren_r;
  logic        i_ack_r;
  logic        d_ack_r;

  logic        grant_i;
  logic        grant_d;
  logic [31:0] load_fmt;
  logic [31:0] merged;

  // On contention the port that did not win last time gets the grant.
  always_comb begin
    grant_d = bus.d_req && (!bus.i_req || (last_grant == PORT_I));
    grant_i = bus.i_req && !grant_d;
  end

  always_comb begin
    load_fmt = bus.mem_q;
    case (size_r)
      2'b00:   load_fmt = {{24{signed_r & bus.mem_q[31]}}, bus.mem_q[31:24]};
      2'b01:   load_fmt = {{16{signed_r & bus.mem_q[31]}}, bus.mem_q[31:16]};
      default: load_fmt = bus.mem_q;
    endcase
    merged = size_r[0] ? {wdata_lo, bus.mem_q[15:0]}
                       : {wdata_lo[7:0], bus.mem_q[23:0]};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= PORT_D;
      port_r     <= PORT_I;
      signed_r   <= 1'b0;
      size_r     <= 2'b00;
      addr_r     <= '0;
      wdata_lo   <= '0;
      mem_data_r <= '0;
      wren_r     <= 1'b0;
      i_ack_r    <= 1'b0;
      d_ack_r    <= 1'b0;
    end else begin
      i_ack_r <= 1'b0;
      d_ack_r <= 1'b0;
      wren_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            last_grant <= PORT_D;
            port_r     <= PORT_D;
            addr_r     <= bus.d_addr;
            size_r     <= bus.d_size;
            signed_r   <= bus.d_signed;
            wdata_lo   <= bus.d_wdata[15:0];
            if (!bus.d_we) begin
              state <= RD_A;
            end else if (bus.d_size[1]) begin
              state      <= WR;
              mem_data_r <= bus.d_wdata;
              wren_r     <= 1'b1;
              d_ack_r    <= 1'b1;
            end else begin
              state <= RMW_A;
            end
          end else if (grant_i) begin
            last_grant <= PORT_I;
            port_r     <= PORT_I;
            addr_r     <= bus.i_addr;
            size_r     <= 2'b10;
            signed_r   <= 1'b0;
            state      <= RD_A;
          end
        end
        RD_A: begin
          state <= RD_D;
          if (port_r == PORT_D) d_ack_r <= 1'b1;
          else                  i_ack_r <= 1'b1;
        end
        RD_D:  state <= IDLE;
        WR:    state <= IDLE;
        RMW_A: state <= RMW_M;
        RMW_M: begin
          state      <= RMW_W;
          mem_data_r <= merged;
          wren_r     <= 1'b1;
          d_ack_r    <= 1'b1;
        end
        RMW_W:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.i_ack       = i_ack_r;
  assign bus.d_ack       = d_ack_r;
  assign bus.mem_address = addr_r;
  assign bus.mem_data    = mem_data_r;
  assign bus.mem_wren    = wren_r;
  assign bus.busy        = (state != IDLE);
  assign bus.i_rdata     = ((state == RD_D) && (port_r == PORT_I)) ? bus.mem_q : '0;
  assign bus.d_rdata     = ((state == RD_D) && (port_r == PORT_D)) ? load_fmt : '0;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: byte-array reference memory predicts
// every ack; a forked monitor pops and compares whenever an ack appears.
module tb_mem_access_ctrl;
  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   wren_cnt   = 0;
  int   store_acks = 0;
  bit   alt_mode  = 1'b0;
  bit   last_port = 1'b1;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [31:0] data;
    int          issue_cyc;
    int          lat;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  logic [7:0] mem [0:65535];
  logic [7:0] rm  [0:65535];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mem_access_ctrl_if bus ();
  mem_access_ctrl dut (.clock(clock), .resetn(resetn), .bus(bus));

  function automatic logic [7:0] init_byte(int i);
    return 8'((i * 37) ^ (i >> 7));
  endfunction

  function automatic logic [15:0] ofs(logic [15:0] a, logic [15:0] k);
    return a + k;
  endfunction

  // mem32 stand-in: registered read of 4 bytes, big-endian, wrapping at 64K.
  initial begin : memory_model
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) mem[i] <= init_byte(i);
    bus.mem_q <= '0;
    forever begin
      @(posedge clock);
      a = bus.mem_address;
      if (bus.mem_wren) begin
        mem[a]               <= bus.mem_data[31:24];
        mem[ofs(a, 16'd1)]   <= bus.mem_data[23:16];
        mem[ofs(a, 16'd2)]   <= bus.mem_data[15:8];
        mem[ofs(a, 16'd3)]   <= bus.mem_data[7:0];
      end
      bus.mem_q <= {mem[a], mem[ofs(a, 16'd1)], mem[ofs(a, 16'd2)], mem[ofs(a, 16'd3)]};
    end
  end

  function automatic logic [31:0] ref_word(logic [15:0] a);
    return {rm[a], rm[ofs(a, 16'd1)], rm[ofs(a, 16'd2)], rm[ofs(a, 16'd3)]};
  endfunction

  function automatic logic [31:0] ref_load(logic [15:0] a, logic [1:0] size, bit sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = rm[a];
    h = {rm[a], rm[ofs(a, 16'd1)]};
    if (size == 2'b00) return sgn ? 32'(signed'(b)) : {24'd0, b};
    if (size == 2'b01) return sgn ? 32'(signed'(h)) : {16'd0, h};
    return ref_word(a);
  endfunction

  task automatic ref_store(logic [15:0] a, logic [1:0] size, logic [31:0] d);
    if (size == 2'b00) begin
      rm[a] = d[7:0];
    end else if (size == 2'b01) begin
      rm[a]             = d[15:8];
      rm[ofs(a, 16'd1)] = d[7:0];
    end else begin
      rm[a]             = d[31:24];
      rm[ofs(a, 16'd1)] = d[23:16];
      rm[ofs(a, 16'd2)] = d[15:8];
      rm[ofs(a, 16'd3)] = d[7:0];
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_idle_outputs(string tag);
    chk({tag, "_busy"},        {31'd0, bus.busy},     32'd0);
    chk({tag, "_mem_wren"},    {31'd0, bus.mem_wren}, 32'd0);
    chk({tag, "_mem_address"}, {16'd0, bus.mem_address}, 32'd0);
    chk({tag, "_mem_data"},    bus.mem_data,          32'd0);
    chk({tag, "_i_ack"},       {31'd0, bus.i_ack},    32'd0);
    chk({tag, "_d_ack"},       {31'd0, bus.d_ack},    32'd0);
    chk({tag, "_i_rdata"},     bus.i_rdata,           32'd0);
    chk({tag, "_d_rdata"},     bus.d_rdata,           32'd0);
  endtask

  task automatic monitor();
    exp_t e;
    bit   p;
    forever begin
      @(negedge clock);
      if (bus.mem_wren) wren_cnt++;
      if (bus.i_ack || bus.d_ack) begin
        chk("ack_overlap", {31'd0, bus.i_ack & bus.d_ack}, 32'd0);
        p = bus.d_ack;
        if (alt_mode) chk("alternation_port", {31'd0, p}, {31'd0, ~last_port});
        last_port = p;
      end
      if (bus.i_ack) begin
        if (iq.size() == 0) begin
          checks++; errors++;
          $display("FAIL i_unexpected_ack actual=ack required=no_ack (cycle %0d)", cyc);
        end else begin
          e = iq.pop_front();
          chk("i_rdata", bus.i_rdata, e.data);
          if (e.lat >= 0) chk("i_latency", 32'(cyc - e.issue_cyc), 32'(e.lat));
        end
      end
      if (bus.d_ack) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL d_unexpected_ack actual=ack required=no_ack (cycle %0d)", cyc);
        end else begin
          e = dq.pop_front();
          if (e.we) begin
            store_acks++;
            chk("store_wren",    {31'd0, bus.mem_wren}, 32'd1);
            chk("store_address", {16'd0, bus.mem_address}, {16'd0, e.addr});
            chk("store_data",    bus.mem_data, e.data);
          end else begin
            chk("d_rdata", bus.d_rdata, e.data);
          end
          if (e.lat >= 0) chk("d_latency", 32'(cyc - e.issue_cyc), 32'(e.lat));
        end
      end
    end
  endtask

  // Presents one request and holds it until acked; expectation is queued at issue.
  task automatic issue(bit port_d, bit we, logic [1:0] size, bit sgn,
                       logic [15:0] addr, logic [31:0] wdata, bit chk_lat);
    exp_t e;
    int   n;
    @(negedge clock);
    e.we        = port_d && we;
    e.addr      = addr;
    e.issue_cyc = cyc;
    e.lat       = !chk_lat ? -1 : (!e.we ? 2 : (size[1] ? 1 : 3));
    if (!port_d) begin
      e.data     = ref_word(addr);
      bus.i_addr = addr;
      bus.i_req  = 1'b1;
      iq.push_back(e);
    end else begin
      if (we) begin
        ref_store(addr, size, wdata);
        e.data = ref_word(addr);
      end else begin
        e.data = ref_load(addr, size, sgn);
      end
      bus.d_we     = we;
      bus.d_size   = size;
      bus.d_signed = sgn;
      bus.d_addr   = addr;
      bus.d_wdata  = wdata;
      bus.d_req    = 1'b1;
      dq.push_back(e);
    end
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(port_d ? bus.d_ack : bus.i_ack) && n < 60);
    if (n >= 60) begin
      checks++; errors++;
      $display("FAIL %s_ack_timeout actual=no_ack required=ack addr=%h", port_d ? "d" : "i", addr);
    end
    if (port_d) bus.d_req = 1'b0;
    else        bus.i_req = 1'b0;
  endtask

  function automatic logic [15:0] rand_daddr();
    if ($urandom_range(0, 3) == 0) return 16'hFFF8 + 16'($urandom_range(0, 7));
    return 16'($urandom_range(0, 255));
  endfunction

  initial begin
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 2'b00; bus.d_signed = 1'b0;
    bus.d_addr = '0;  bus.d_wdata = '0;
    for (int i = 0; i < 65536; i++) rm[i] = init_byte(i);
    fork monitor(); join_none

    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    resetn = 1'b1;

    // Directed scenarios with latency checks (DUT idle at each issue).
    issue(1, 1, 2'b10, 0, 16'h0010, 32'h11223344, 1);
    issue(1, 0, 2'b10, 0, 16'h0010, 32'h0, 1);
    issue(1, 1, 2'b00, 0, 16'h0011, 32'h000000AB, 1);
    issue(1, 0, 2'b10, 0, 16'h0010, 32'h0, 1);
    issue(1, 0, 2'b00, 1, 16'h0011, 32'h0, 1);
    issue(1, 0, 2'b00, 0, 16'h0011, 32'h0, 1);
    issue(1, 1, 2'b10, 0, 16'h0014, 32'h00000000, 1);
    issue(1, 1, 2'b01, 0, 16'h0013, 32'h0000BEEF, 1);
    issue(1, 0, 2'b10, 0, 16'h0012, 32'h0, 1);
    issue(1, 0, 2'b01, 1, 16'h0013, 32'h0, 1);
    issue(1, 1, 2'b11, 0, 16'hFFFE, 32'hCAFEF00D, 1);
    issue(1, 0, 2'b00, 0, 16'h0000, 32'h0, 1);
    issue(1, 0, 2'b00, 0, 16'h0001, 32'h0, 1);
    issue(1, 0, 2'b00, 0, 16'hFFFE, 32'h0, 1);
    issue(0, 0, 2'b10, 0, 16'hFFFE, 32'h0, 1);

    // Byte store aborted by reset in RMW_M: memory must stay untouched.
    @(negedge clock);
    bus.d_we = 1'b1; bus.d_size = 2'b00; bus.d_signed = 1'b0;
    bus.d_addr = 16'h0010; bus.d_wdata = 32'h0000005A; bus.d_req = 1'b1;
    @(negedge clock);
    chk("abort_busy_in_rmw", {31'd0, bus.busy}, 32'd1);
    @(negedge clock);
    resetn = 1'b0;
    bus.d_req = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("abort_wren_low", {31'd0, bus.mem_wren}, 32'd0);
    end
    check_idle_outputs("abort");
    resetn = 1'b1;
    issue(1, 0, 2'b10, 0, 16'h0010, 32'h0, 1);

    // Contention held from reset: first grant to I, then strict alternation.
    @(negedge clock);
    resetn    = 1'b0;
    alt_mode  = 1'b1;
    last_port = 1'b1;
    fork
      begin
        for (int k = 0; k < 5; k++) issue(0, 0, 2'b10, 0, 16'h4000 + 16'($urandom_range(0, 255)), 32'h0, 0);
      end
      begin
        for (int k = 0; k < 5; k++) issue(1, 0, 2'b10, 0, rand_daddr(), 32'h0, 0);
      end
      begin
        repeat (3) @(negedge clock);
        resetn = 1'b1;
      end
    join
    alt_mode = 1'b0;

    // Randomized traffic on both ports; fetches stay clear of the data region.
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clock);
          issue(0, 0, 2'b10, 0, 16'h4000 + 16'($urandom_range(0, 255)), 32'h0, 0);
        end
      end
      begin
        for (int k = 0; k < 60; k++) begin
          repeat ($urandom_range(0, 2)) @(negedge clock);
          issue(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                rand_daddr(), $urandom, 0);
        end
      end
    join

    repeat (6) @(negedge clock);
    chk("i_queue_drained", 32'(iq.size()), 32'd0);
    chk("d_queue_drained", 32'(dq.size()), 32'd0);
    chk("wren_cycles_vs_store_acks", 32'(wren_cnt), 32'(store_acks));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
